noc_serial_receiver_fifo: RTL and testbench

//  Parametrised NoC flit deserialiser with an output packet FIFO. It is the successor to the single-register serial receiver.

---
 rtl/noc_serial_receiver_fifo.sv | 157 +++++++++++++++
 tb/tb_noc_serial_receiver_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_serial_receiver_fifo.sv
// rtl/noc_serial_receiver_fifo.sv - NoC flit deserialiser with framing check and output packet FIFO
module noc_serial_receiver_fifo #(
  parameter int FLIT_BITS    = 32,
  parameter int PACKET_BITS  = 70,
  parameter int PADDING_BITS = 26,
  parameter int DEPTH        = 4,
  parameter int ERR_CNT_BITS = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic                                       flit_valid,
  input  logic [FLIT_BITS-1:0]                       flit_data,
  input  logic                                       flit_last,
  output logic                                       flit_ready,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [PACKET_BITS-1:0]                     out_packet,
  output logic [(PADDING_BITS > 0 ? PADDING_BITS : 1)-1:0] out_padding,
  output logic [$clog2(DEPTH+1)-1:0]                 level,
  output logic                                       framing_err,
  output logic [ERR_CNT_BITS-1:0]                    err_count
);

  localparam int TOTAL  = PACKET_BITS + PADDING_BITS;
  localparam int FLITS  = (TOTAL + FLIT_BITS - 1) / FLIT_BITS;
  localparam int PART_W = (FLITS - 1) * FLIT_BITS;
  localparam int CNT_W  = $clog2(FLITS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);

  typedef enum logic {COLLECT, RESYNC} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PART_W-1:0]       partial_q;
  logic [TOTAL-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    framing_err_q;
  logic [ERR_CNT_BITS-1:0] err_count_q;

  logic             flit_acc, cnt_last, push, pop, err_evt;
  logic [TOTAL-1:0] word, head;

  assign cnt_last   = (cnt_q == CNT_W'(FLITS - 1));
  // Only the final-flit push can overflow, so only that case is throttled.
  assign flit_ready = !rst && !flush &&
                      (state_q == RESYNC || !cnt_last || level_q != LVL_W'(DEPTH));
  assign flit_acc   = flit_valid && flit_ready;
  assign word       = TOTAL'({flit_data, partial_q});
  assign pop        = (level_q != '0) && out_ready && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    err_evt = 1'b0;
    if (flit_acc) begin
      if (state_q == RESYNC) begin
        if (flit_last) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end else if (!cnt_last) begin
        if (flit_last) begin
          cnt_d   = '0;
          err_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (flit_last) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        err_evt = 1'b1;
        cnt_d   = '0;
        state_d = RESYNC;
      end
    end
    if (flush) begin
      state_d = COLLECT;
      cnt_d   = '0;
      push    = 1'b0;
    end
  end

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= COLLECT;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      framing_err_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      framing_err_q <= err_evt;
      if (err_evt && err_count_q != '1) begin
        err_count_q <= err_count_q + 1'b1;
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // Payload storage carries no reset; its contents are qualified by cnt/level.
  always_ff @(posedge clk) begin
    if (flit_acc && state_q == COLLECT && !cnt_last) begin
      for (int k = 0; k < FLITS - 1; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          partial_q[k*FLIT_BITS +: FLIT_BITS] <= flit_data;
        end
      end
    end
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (level_q != '0);
  assign out_packet  = head[PACKET_BITS-1:0];
  assign level       = level_q;
  assign framing_err = framing_err_q;
  assign err_count   = err_count_q;

  generate
    if (PADDING_BITS > 0) begin : g_pad
      assign out_padding = head[TOTAL-1:PACKET_BITS];
    end else begin : g_nopad
      assign out_padding = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_noc_serial_receiver_fifo.sv
// tb/tb_noc_serial_receiver_fifo.sv - scoreboard bench for noc_serial_receiver_fifo
module tb_noc_serial_receiver_fifo;

  logic        clk = 1'b0;
  logic        rst, flush, flit_valid, flit_last, out_ready;
  logic [31:0] flit_data;
  logic        flit_ready, out_valid, framing_err;
  logic [69:0] out_packet;
  logic [25:0] out_padding;
  logic [2:0]  level;
  logic [7:0]  err_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [95:0] sb_q[$];

  noc_serial_receiver_fifo #(
    .FLIT_BITS(32), .PACKET_BITS(70), .PADDING_BITS(26), .DEPTH(4), .ERR_CNT_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .flit_valid(flit_valid), .flit_data(flit_data), .flit_last(flit_last), .flit_ready(flit_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet), .out_padding(out_padding),
    .level(level), .framing_err(framing_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [95:0] mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return {c, b, a};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", {26'd0, out_packet}, 128'd0);
        end else begin
          logic [95:0] e;
          e = sb_q.pop_front();
          check("out_packet", {58'd0, out_packet}, {58'd0, e[69:0]});
          check("out_padding", {102'd0, out_padding}, {102'd0, e[95:70]});
        end
      end
    end
  end

  task automatic send_flit(input logic [31:0] d, input logic last);
    int t;
    t = 0;
    flit_valid = 1'b1;
    flit_data  = d;
    flit_last  = last;
    @(negedge clk);
    while (!flit_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!flit_ready) check("flit_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
    flit_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input bit exp);
    if (exp) sb_q.push_back(mk(a, b, c));
    send_flit(a, 1'b0);
    send_flit(b, 1'b0);
    send_flit(c, 1'b1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((level != 0 || sb_q.size() != 0) && t < 100) begin
      t++;
      cycle();
    end
    check(name, {96'd0, t < 100}, 128'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flit_valid = 1'b0; flit_last = 1'b0; flit_data = '0; out_ready = 1'b0;
    @(negedge clk);
    check("reset_flit_ready", {127'd0, flit_ready}, 128'd0);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_level", {125'd0, level}, 128'd0);
    check("reset_framing_err", {127'd0, framing_err}, 128'd0);
    check("reset_err_count", {120'd0, err_count}, 128'd0);
    check("idle_flit_ready", {127'd0, flit_ready}, 128'd1);
    cycle();

    // 1: single packet, hand-computed head
    out_ready = 1'b1;
    sb_q.push_back({26'h0CC_CCCC, 70'h33_2222_2222_1111_1111});
    send_flit(32'h1111_1111, 1'b0);
    send_flit(32'h2222_2222, 1'b0);
    check("t1_not_valid_early", {127'd0, out_valid}, 128'd0);
    send_flit(32'h3333_3333, 1'b1);
    check("t1_latency_valid", {127'd0, out_valid}, 128'd1);
    drain("t1_drain");

    // 2: fill FIFO, backpressure, ordering
    out_ready = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      send_pkt(32'hA000_0000 + p, 32'hB000_0000 + p, 32'hC000_0000 + p, 1'b1);
      check($sformatf("t2_level_%0d", p), {125'd0, level}, p);
    end
    sb_q.push_back(mk(32'hA000_0005, 32'hB000_0005, 32'hC000_0005));
    send_flit(32'hA000_0005, 1'b0);
    send_flit(32'hB000_0005, 1'b0);
    flit_valid = 1'b1; flit_data = 32'hC000_0005; flit_last = 1'b1;
    @(negedge clk);
    check("t2_full_flit_ready", {127'd0, flit_ready}, 128'd0);
    check("t2_full_level", {125'd0, level}, 128'd4);
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("t2_level_after_pop", {125'd0, level}, 128'd3);
    send_flit(32'hC000_0005, 1'b1);
    check("t2_level_refill", {125'd0, level}, 128'd4);
    out_ready = 1'b1;
    drain("t2_drain");

    // 3: early end
    send_flit(32'hDEAD_0001, 1'b0);
    send_flit(32'hDEAD_0002, 1'b1);
    check("t3_framing_err", {127'd0, framing_err}, 128'd1);
    check("t3_err_count", {120'd0, err_count}, 128'd1);
    check("t3_no_push", {125'd0, level}, 128'd0);
    cycle();
    check("t3_err_one_cycle", {127'd0, framing_err}, 128'd0);
    send_pkt(32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 1'b1);
    drain("t3_drain");

    // 4: late end, resync through junk
    send_flit(32'h5555_0001, 1'b0);
    send_flit(32'h5555_0002, 1'b0);
    send_flit(32'h5555_0003, 1'b0);
    check("t4_framing_err", {127'd0, framing_err}, 128'd1);
    send_flit(32'h6666_0001, 1'b0);
    send_flit(32'h6666_0002, 1'b0);
    send_flit(32'h6666_0003, 1'b1);
    check("t4_no_extra_err", {120'd0, err_count}, 128'd2);
    check("t4_junk_dropped", {125'd0, level}, 128'd0);
    send_pkt(32'h7777_0001, 32'h7777_0002, 32'h7777_0003, 1'b1);
    drain("t4_drain");

    // 5: flush drops buffered and partial data
    out_ready = 1'b0;
    send_pkt(32'h8888_0001, 32'h8888_0002, 32'h8888_0003, 1'b0);
    send_pkt(32'h9999_0001, 32'h9999_0002, 32'h9999_0003, 1'b0);
    send_flit(32'hAAAA_0001, 1'b0);
    check("t5_level_pre", {125'd0, level}, 128'd2);
    flush = 1'b1;
    @(negedge clk);
    check("t5_flush_flit_ready", {127'd0, flit_ready}, 128'd0);
    cycle();
    flush = 1'b0;
    check("t5_out_valid", {127'd0, out_valid}, 128'd0);
    check("t5_level", {125'd0, level}, 128'd0);
    check("t5_err_kept", {120'd0, err_count}, 128'd2);
    out_ready = 1'b1;
    send_pkt(32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003, 1'b1);
    drain("t5_drain");

    // 6: saturation then mid-packet reset
    for (int i = 0; i < 253; i++) begin
      send_flit(32'hEEEE_0000 + i, 1'b0);
      send_flit(32'hEEEE_1000 + i, 1'b1);
    end
    check("t6_err_255", {120'd0, err_count}, 128'd255);
    send_flit(32'hEEEE_2000, 1'b0);
    send_flit(32'hEEEE_2001, 1'b1);
    check("t6_sat_pulse", {127'd0, framing_err}, 128'd1);
    check("t6_saturated", {120'd0, err_count}, 128'd255);
    send_flit(32'hCCCC_0001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_flit_ready", {127'd0, flit_ready}, 128'd0);
    cycle();
    rst = 1'b0;
    check("t6_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("t6_rst_level", {125'd0, level}, 128'd0);
    check("t6_rst_framing_err", {127'd0, framing_err}, 128'd0);
    check("t6_rst_err_count", {120'd0, err_count}, 128'd0);
    send_pkt(32'hFACE_0001, 32'hFACE_0002, 32'hFACE_0003, 1'b1);
    drain("t6_drain");
    check("sb_empty", {96'd0, sb_q.size()}, 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
